trace_capture_ctrl: RTL
=======================

// Module: trace_capture_ctrl
// PURPOSE
//  Sequences trace capture for the pipeline trace unit.
//  - Gates completed trace records from the write-back tracker into a FIFO,
//    using an enable and optional start/stop instruction-address triggers.
//  - Drains buffered records over a valid/ready stream to the trace sink.
//  - Reports state, fill level and dropped-record count.
// PARAMETERS
//  TRACE_WIDTH  128  width of one flattened trace record
//  ADDR_WIDTH   32   instruction address width for trigger compare
//  DEPTH        8    FIFO entries; power of 2, >= 2
//  CNT_WIDTH    16   width of dropped-record counter
// PORTS
//  clk              in   1                    clock, rising edge
//  rst              in   1                    reset, asynchronous, active-high
//  cfg_enable_i     in   1                    level: capture session requested
//  cfg_use_trig_i   in   1                    1: wait for start-address match
//  cfg_start_addr_i in   ADDR_WIDTH           start trigger address
//  cfg_stop_addr_i  in   ADDR_WIDTH           stop trigger address
//  trace_valid_i    in   1                    one-cycle strobe: record complete
//  trace_addr_i     in   ADDR_WIDTH           instruction address of the record
//  trace_data_i     in   TRACE_WIDTH          record payload
//  out_valid_o      out  1                    head record available
//  out_data_o       out  TRACE_WIDTH          head record
//  out_ready_i      in   1                    sink accepts head this cycle
//  state_o          out  2                    IDLE=0 ARMED=1 CAPTURE=2 DRAIN=3
//  fill_o           out  $clog2(DEPTH)+1      FIFO occupancy, 0..DEPTH
//  dropped_o        out  CNT_WIDTH            records lost to a full FIFO
//  done_o           out  1                    1-cycle pulse: session finished
// BEHAVIOUR
//  Reset: state IDLE; FIFO empty; out_valid_o=0; out_data_o=0; fill_o=0;
//    dropped_o=0; done_o=0. Reset mid-session discards all FIFO contents.
//  Eligible record: trace_valid_i=1 while in ARMED with trace_addr_i ==
//    cfg_start_addr_i, or while in CAPTURE.
//  FSM (registered):
//  - IDLE: if cfg_enable_i=1, go to ARMED when cfg_use_trig_i=1, else to
//    CAPTURE. dropped_o clears on leaving IDLE. Records seen in IDLE are ignored.
//  - ARMED: on a start-address match, push that record and go to CAPTURE.
//    If cfg_enable_i=0 (takes priority over a match), go to IDLE with no push
//    and no done_o pulse.
//  - CAPTURE: push every valid record. Go to DRAIN when trace_addr_i ==
//    cfg_stop_addr_i; that record is pushed. Also go to DRAIN on
//    cfg_enable_i=0; a record valid in that same cycle is still pushed.
//    The stop address is not checked in ARMED, so start==stop ends the
//    session on the next match.
//  - DRAIN: no pushes; cfg_enable_i ignored. When fill=0, go to IDLE and
//    assert done_o for 1 cycle.
//  FIFO:
//  - Storage is registered with first-word fall-through: out_valid_o = (fill != 0)
//    and out_data_o = head entry. out_data_o holds its value when not valid.
//  - A push at cycle N appears on the outputs at N+1 when the FIFO was empty.
//  - Pop occurs when out_valid_o & out_ready_i. out_data_o holds stable while
//    out_valid_o=1 and out_ready_i=0.
//  - Push is accepted if fill < DEPTH, or fill == DEPTH with a pop in the
//    same cycle. Otherwise the record is dropped.
//  - Each drop increments dropped_o, saturating at all-ones.
//  - Simultaneous push and pop leaves fill unchanged.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  Address compares are exact and full-width; there is no combinational path
//    from trace_*_i to out_*.
// TESTING
//  1 Reset: assert rst mid-CAPTURE with fill=5 -> next cycle state_o=0,
//    fill_o=0, out_valid_o=0, dropped_o=0.
//  2 No trigger: enable=1, use_trig=0, 3 records at 0x100/104/108, ready=1
//    -> out_data order matches input, each 1 cycle after its push; enable=0
//    -> DRAIN, then IDLE with done_o pulsing once.
//  3 Trigger: start=0x200, stop=0x220, records 0x1FC..0x224 step 4
//    -> only 0x200..0x220 are output (9 records); 0x224 is dropped silently.
//  4 Overflow: DEPTH=8, ready=0, 11 records in CAPTURE -> fill_o=8,
//    dropped_o=3; then ready=1 -> 8 records output in order, FIFO empty.
//  5 Full with simultaneous pop: fill=8, push and pop in the same cycle
//    -> fill stays 8, dropped_o unchanged, new record at the tail.
//  6 Abort ARMED: use_trig=1, enable=0 before any match -> IDLE, done_o=0,
//    nothing output.

Source files
------------

// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: gates completed trace records into a first-word
// fall-through FIFO using enable and start/stop address triggers, then drains.
module trace_capture_ctrl #(
    parameter int TRACE_WIDTH = 128,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_enable_i,
    input  logic                     cfg_use_trig_i,
    input  logic [ADDR_WIDTH-1:0]    cfg_start_addr_i,
    input  logic [ADDR_WIDTH-1:0]    cfg_stop_addr_i,
    input  logic                     trace_valid_i,
    input  logic [ADDR_WIDTH-1:0]    trace_addr_i,
    input  logic [TRACE_WIDTH-1:0]   trace_data_i,
    output logic                     out_valid_o,
    output logic [TRACE_WIDTH-1:0]   out_data_o,
    input  logic                     out_ready_i,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic [CNT_WIDTH-1:0]     dropped_o,
    output logic                     done_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    // state | meaning
    // IDLE    | no session; records ignored
    // ARMED   | waiting for a record at the start address
    // CAPTURE | every valid record is pushed
    // DRAIN   | no pushes; wait for the FIFO to empty
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [TRACE_WIDTH-1:0]   out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]     dropped_q, dropped_d;
    logic                     done_q, done_d;
    logic [TRACE_WIDTH-1:0]   mem_q [DEPTH];

    logic start_hit;
    logic stop_hit;
    logic push_req;
    logic clr_drop;
    logic pop;
    logic push;
    logic drop;

    assign start_hit = trace_valid_i && (trace_addr_i == cfg_start_addr_i);
    assign stop_hit  = trace_valid_i && (trace_addr_i == cfg_stop_addr_i);

    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        clr_drop = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_enable_i) begin
                    clr_drop = 1'b1;
                    state_d  = cfg_use_trig_i ? S_ARMED : S_CAPTURE;
                end
            end
            S_ARMED: begin
                // Dropping enable wins over a simultaneous start match.
                if (!cfg_enable_i) begin
                    state_d = S_IDLE;
                end else if (start_hit) begin
                    push_req = 1'b1;
                    state_d  = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                push_req = trace_valid_i;
                if (stop_hit || !cfg_enable_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fill_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop  = (fill_q != '0) && out_ready_i;
    assign push = push_req && ((fill_q != FILL_FULL) || pop);
    assign drop = push_req && !push;

    always_comb begin
        fill_d     = fill_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        out_data_d = out_data_q;
        dropped_d  = dropped_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase

        // Head register: load the incoming record when it becomes the head,
        // otherwise advance to the next stored entry; hold when emptied.
        if (push && ((fill_q == '0) || (pop && (fill_q == FILL_ONE)))) begin
            out_data_d = trace_data_i;
        end else if (pop && (fill_q > FILL_ONE)) begin
            out_data_d = mem_q[rd_ptr_q + PTR_ONE];
        end

        if (clr_drop) begin
            dropped_d = '0;
        end else if (drop && (dropped_q != '1)) begin
            dropped_d = dropped_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fill_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            out_data_q <= '0;
            dropped_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            out_data_q <= out_data_d;
            dropped_q  <= dropped_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= trace_data_i;
        end
    end

    assign out_valid_o = (fill_q != '0);
    assign out_data_o  = out_data_q;
    assign state_o     = state_q;
    assign fill_o      = fill_q;
    assign dropped_o   = dropped_q;
    assign done_o      = done_q;

endmodule
